dsc_mul_seq: RTL and testbench

- Sequencer that sits directly upstream of the dsc_mul datapath and also consumes its result.
- Accepts one operand pair per transaction on a valid/ready input port, drives the datapath's operands and enable, and issues a one-cycle clear before each run.
- Runs the full stochastic stream length of 2^(NUM_INPUTS*SNG_WIDTH) cycles, or stops early on the datapath's ov.
- Captures the binary product and presents it on a valid/ready output port with the cycle count consumed.

---
 rtl/dsc_mul_seq.sv | 132 +++++++++++++
 tb/tb_dsc_mul_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_seq.sv
// Sequencer wrapping the dsc_mul datapath: accepts an operand pair, clears and runs the
// stochastic stream (full length or until mul_ov), then returns the captured product with its cycle count.
module dsc_mul_seq #(
    parameter int SNG_WIDTH  = 4,
    parameter int NUM_INPUTS = 2,
    parameter bit EARLY_STOP = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [SNG_WIDTH-1:0]                in_a,
    input  logic [SNG_WIDTH-1:0]                in_b,
    output logic [SNG_WIDTH-1:0]                mul_a,
    output logic [SNG_WIDTH-1:0]                mul_b,
    output logic                                mul_en,
    output logic                                mul_clr,
    input  logic [NUM_INPUTS*SNG_WIDTH-1:0]     mul_z,
    input  logic                                mul_ov,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0]     out_z,
    output logic [NUM_INPUTS*SNG_WIDTH:0]       out_cycles,
    output logic                                busy
);

    localparam int RW = NUM_INPUTS * SNG_WIDTH;
    localparam logic [RW:0] CNT_LAST = {1'b0, {RW{1'b1}}};
    localparam logic [RW:0] CNT_ONE  = {{RW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [RW:0]            r_cnt;
    logic                   r_in_ready;
    logic [SNG_WIDTH-1:0]   r_mul_a;
    logic [SNG_WIDTH-1:0]   r_mul_b;
    logic                   r_mul_en;
    logic                   r_mul_clr;
    logic                   r_out_valid;
    logic [RW-1:0]          r_out_z;
    logic [RW:0]            r_out_cycles;
    logic                   r_busy;

    logic                   w_run_last;

    // Natural end of stream and early shutoff coincide into a single termination.
    assign w_run_last = (r_cnt == CNT_LAST) || (EARLY_STOP & mul_ov);

    // Every output flag is registered alongside the state transition that implies it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_in_ready   <= 1'b1;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_en     <= 1'b0;
            r_mul_clr    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_z      <= '0;
            r_out_cycles <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_mul_a    <= in_a;
                        r_mul_b    <= in_b;
                        r_in_ready <= 1'b0;
                        r_mul_clr  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_cnt     <= '0;
                    r_mul_clr <= 1'b0;
                    r_mul_en  <= 1'b1;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    // After the final RUN cycle the counter holds N, the number of cycles used.
                    r_cnt <= r_cnt + CNT_ONE;
                    if (w_run_last) begin
                        r_mul_en <= 1'b0;
                        r_state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_out_z      <= mul_z;
                    r_out_cycles <= r_cnt;
                    r_out_valid  <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_mul_en    <= 1'b0;
                    r_mul_clr   <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign mul_en     = r_mul_en;
    assign mul_clr    = r_mul_clr;
    assign out_valid  = r_out_valid;
    assign out_z      = r_out_z;
    assign out_cycles = r_out_cycles;
    assign busy       = r_busy;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Bench for dsc_mul_seq: two instances (EARLY_STOP=0 and 1), each driving a counting
// unary-product mock datapath; expected results are queued at acceptance and checked by monitors.
module tb_dsc_mul_seq;

    localparam int LIM = 2000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       in_valid   [2];
    logic       in_ready   [2];
    logic [3:0] in_a       [2];
    logic [3:0] in_b       [2];
    logic [3:0] mul_a      [2];
    logic [3:0] mul_b      [2];
    logic       mul_en     [2];
    logic       mul_clr    [2];
    logic [7:0] mul_z      [2];
    logic       mul_ov     [2];
    logic       out_valid  [2];
    logic       out_ready  [2];
    logic [7:0] out_z      [2];
    logic [8:0] out_cycles [2];
    logic       busy       [2];

    logic [7:0] m_cnt  [2];
    logic       ov_en  [2];
    logic [7:0] ov_idx [2];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int en_cnt0 = 0;
    int clr_cnt0 = 0;
    int viol = 0;

    logic [16:0] exp0[$];
    logic [16:0] exp1[$];
    int          rise0[$];
    int          rise1[$];
    logic        prev_ov0 = 1'b0;
    logic        prev_ov1 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsc_mul_seq #(.SNG_WIDTH(4), .NUM_INPUTS(2), .EARLY_STOP(1'b0)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_en(mul_en[0]), .mul_clr(mul_clr[0]),
        .mul_z(mul_z[0]), .mul_ov(mul_ov[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_z(out_z[0]),
        .out_cycles(out_cycles[0]), .busy(busy[0])
    );

    dsc_mul_seq #(.SNG_WIDTH(4), .NUM_INPUTS(2), .EARLY_STOP(1'b1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_en(mul_en[1]), .mul_clr(mul_clr[1]),
        .mul_z(mul_z[1]), .mul_ov(mul_ov[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_z(out_z[1]),
        .out_cycles(out_cycles[1]), .busy(busy[1])
    );

    // Mock datapath: over a full 256-cycle stream it counts exactly a*b hits.
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_cnt[i] <= 8'd0;
                mul_z[i] <= 8'd0;
            end else if (mul_clr[i]) begin
                m_cnt[i] <= 8'd0;
                mul_z[i] <= 8'd0;
            end else if (mul_en[i]) begin
                m_cnt[i] <= m_cnt[i] + 8'd1;
                if ((m_cnt[i][3:0] < mul_a[i]) && (m_cnt[i][7:4] < mul_b[i]))
                    mul_z[i] <= mul_z[i] + 8'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mul_ov[i] = ov_en[i] && (m_cnt[i] == ov_idx[i]);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    task automatic tmo(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic logic [29:0] outs(input int d);
        return {in_ready[d], mul_a[d], mul_b[d], mul_en[d], mul_clr[d], out_valid[d],
                out_z[d], out_cycles[d], busy[d]};
    endfunction

    // Monitors: latency on out_valid rise, payload on each result handshake.
    always @(negedge clk) begin
        if (mul_en[0]) en_cnt0 <= en_cnt0 + 1;
        if (mul_clr[0]) clr_cnt0 <= clr_cnt0 + 1;
        if (busy[0] && in_ready[0]) viol <= viol + 1;
        if (busy[1] && in_ready[1]) viol <= viol + 1;
        if (out_valid[0] && !prev_ov0) begin
            if (rise0.size() == 0) chk("dut0_unexpected_valid", 64'd1, 64'd0);
            else chk("dut0_latency", cyc, rise0.pop_front());
        end
        prev_ov0 <= out_valid[0];
        if (out_valid[0] && out_ready[0]) begin
            if (exp0.size() == 0) chk("dut0_unexpected_result", 64'd1, 64'd0);
            else chk("dut0_result_z_cycles", {out_z[0], out_cycles[0]}, exp0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (out_valid[1] && !prev_ov1) begin
            if (rise1.size() == 0) chk("dut1_unexpected_valid", 64'd1, 64'd0);
            else chk("dut1_latency", cyc, rise1.pop_front());
        end
        prev_ov1 <= out_valid[1];
        if (out_valid[1] && out_ready[1]) begin
            if (exp1.size() == 0) chk("dut1_unexpected_result", 64'd1, 64'd0);
            else chk("dut1_result_z_cycles", {out_z[1], out_cycles[1]}, exp1.pop_front());
        end
    end

    task automatic send(input int d, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] ez, input logic [8:0] en, input bit hold);
        int t = 0;
        @(negedge clk);
        in_a[d] = a;
        in_b[d] = b;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && t < LIM) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIM) begin
            tmo("accept");
            in_valid[d] = 1'b0;
        end else begin
            if (d == 0) begin
                exp0.push_back({ez, en});
                rise0.push_back(cyc + 1 + int'(en) + 2);
            end else begin
                exp1.push_back({ez, en});
                rise1.push_back(cyc + 1 + int'(en) + 2);
            end
            @(negedge clk);
            if (hold) begin
                in_a[d] = 4'd9;
                in_b[d] = 4'd9;
            end else begin
                in_valid[d] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input int d);
        int t = 0;
        while (((d == 0) ? exp0.size() : exp1.size()) != 0 && t < LIM) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIM) tmo("result_wait");
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_a[i]      = 4'd0;
            in_b[i]      = 4'd0;
            out_ready[i] = 1'b1;
            ov_en[i]     = 1'b0;
            ov_idx[i]    = 8'd0;
        end

        // Reset values and idle behaviour
        #12;
        chk("reset_outs_dut0", outs(0), {1'b1, 29'd0});
        chk("reset_outs_dut1", outs(1), {1'b1, 29'd0});
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_rdy_busy_en_vld", {in_ready[0], busy[0], mul_en[0], out_valid[0]}, 4'b1000);
        end

        // Full-length run, 8*8
        en_cnt0 = 0;
        clr_cnt0 = 0;
        send(0, 4'd8, 4'd8, 8'd64, 9'd256, 1'b0);
        wait_idle(0);
        chk("clr_pulse_count", clr_cnt0, 1);
        chk("en_high_count", en_cnt0, 256);

        // Back-to-back transactions accepted in order
        send(0, 4'd15, 4'd15, 8'd225, 9'd256, 1'b0);
        send(0, 4'd3, 4'd5, 8'd15, 9'd256, 1'b0);
        wait_idle(0);

        // Early stop: mul_ov at RUN index 40, 0 and 255
        ov_en[1] = 1'b1;
        ov_idx[1] = 8'd40;
        send(1, 4'd8, 4'd8, 8'd24, 9'd41, 1'b0);
        wait_idle(1);
        ov_idx[1] = 8'd0;
        send(1, 4'd3, 4'd5, 8'd1, 9'd1, 1'b0);
        wait_idle(1);
        ov_idx[1] = 8'd255;
        send(1, 4'd3, 4'd5, 8'd15, 9'd256, 1'b0);
        wait_idle(1);
        ov_en[1] = 1'b0;

        // mul_ov ignored with EARLY_STOP=0
        ov_en[0] = 1'b1;
        ov_idx[0] = 8'd40;
        send(0, 4'd8, 4'd8, 8'd64, 9'd256, 1'b0);
        wait_idle(0);
        ov_en[0] = 1'b0;

        // Result backpressure with in_valid held high
        out_ready[0] = 1'b0;
        send(0, 4'd2, 4'd3, 8'd6, 9'd256, 1'b1);
        begin
            int t = 0;
            while (!out_valid[0] && t < LIM) begin
                @(negedge clk);
                t++;
            end
            if (t >= LIM) tmo("bp_valid_wait");
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_z_cyc_rdy_a", {out_z[0], out_cycles[0], in_ready[0], out_valid[0], mul_a[0]},
                {8'd6, 9'd256, 1'b0, 1'b1, 4'd2});
        end
        @(posedge clk);
        #2 out_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        chk("bp_idle_after_accept", {in_ready[0], out_valid[0], busy[0]}, 3'b100);
        @(negedge clk);
        chk("bp_no_second_capture", {busy[0], mul_a[0]}, {1'b0, 4'd2});

        // Reset asserted mid-RUN discards the pending result
        en_cnt0 = 0;
        send(0, 4'd5, 4'd7, 8'd35, 9'd256, 1'b0);
        begin
            int t = 0;
            while (en_cnt0 < 100 && t < LIM) begin
                @(negedge clk);
                t++;
            end
            if (t >= LIM) tmo("run100_wait");
        end
        #1 rst = 1'b0;
        #1 chk("midrun_reset_outs", outs(0), {1'b1, 29'd0});
        exp0.delete();
        rise0.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {in_ready[0], busy[0], out_valid[0]}, 3'b100);
        send(0, 4'd2, 4'd4, 8'd8, 9'd256, 1'b0);
        wait_idle(0);

        chk("busy_and_ready_overlap", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
